// File: rtl/read_buffer_responder.sv
// read_buffer_responder: FIFO that answers each held read request with one registered word and a one-cycle valid pulse.
// Ports: clk, rst (async, active-low); write_en/write_data push words;
// full/empty/count report occupancy and overflow is a sticky dropped-push flag;
// read_req_buffer requests a word; valid pulses for one cycle while read_data holds it.
module read_buffer_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  read_req_buffer,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESP = 2'd2} state_t;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  state_t                  r_state, w_next;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_count;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_overflow;
  logic                    w_pop, w_push, w_push_blocked;
  // The pop in FETCH frees a slot on the same edge, so a push alongside it is taken even at full.
  assign w_pop          = r_state == FETCH;
  assign w_push_blocked = r_count == FULL_CNT && !w_pop;
  assign w_push         = write_en && !w_push_blocked;
  assign full      = r_count == FULL_CNT;
  assign empty     = r_count == '0;
  assign count     = r_count;
  assign read_data = r_read_data;
  assign overflow  = r_overflow;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE && read_req_buffer && !empty) ? FETCH :
             (r_state == FETCH) ? RESP : IDLE;
    valid  = r_state == RESP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_read_data <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_read_data <= r_mem[r_rd_ptr];
      end
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
      if (write_en && w_push_blocked) r_overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= write_data;
  end
endmodule

// File: tb/tb_read_buffer_responder.sv
// tb_read_buffer_responder: directed scoreboard bench for read_buffer_responder.
module tb_read_buffer_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [15:0] write_data;
  logic        full, empty, overflow, valid;
  logic [3:0]  count;
  logic        read_req_buffer;
  logic [15:0] read_data;
  logic [15:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  read_buffer_responder #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_data(write_data),
    .full(full), .empty(empty), .count(count), .read_req_buffer(read_req_buffer),
    .valid(valid), .read_data(read_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst && valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_valid: got data 0x%0h, expected no response", read_data);
      end else begin
        check("read_data", read_data, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [15:0] w);
    write_en = 1'b1;
    write_data = w;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 2);
    @(posedge clk); #1;
    read_req_buffer = 1'b0;
    check({tag, "_pulse_width"}, valid, 0);
  endtask

  task automatic request(input logic [15:0] w, input string tag);
    exp_q.push_back(w);
    read_req_buffer = 1'b1;
    wait_valid(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    write_en = 1'b0;
    write_data = '0;
    read_req_buffer = 1'b0;
    #2;
    check("rst_valid", valid, 0);
    check("rst_read_data", read_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic read
    push(16'h00A1);
    push(16'h00B2);
    check("basic_count2", count, 2);
    request(16'h00A1, "basic1");
    check("basic_count1", count, 1);
    request(16'h00B2, "basic2");
    check("basic_empty", empty, 1);

    // request while empty
    read_req_buffer = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_req_no_valid", valid, 0);
    end
    exp_q.push_back(16'h1234);
    push(16'h1234);
    check("empty_req_count", count, 1);
    wait_valid("empty_req");

    // fill and overflow
    for (int i = 0; i < 9; i++) begin
      push(16'(i));
      if (i == 7) begin
        check("fill_full", full, 1);
        check("fill_count8", count, 8);
        check("fill_no_overflow", overflow, 0);
      end
    end
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 8);
    for (int i = 0; i < 8; i++) request(16'(i), "drain");
    check("ovf_sticky", overflow, 1);
    check("drain_empty", empty, 1);

    // wrap-around with simultaneous push/pop
    for (int i = 0; i < 3; i++) push(16'(100 + i));
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(16'(100 + i));
      read_req_buffer = 1'b1;
      @(posedge clk); #1;
      write_en = 1'b1;
      write_data = 16'(103 + i);
      @(posedge clk); #1;
      write_en = 1'b0;
      check("wrap_count", count, 3);
      @(posedge clk); #1;
      read_req_buffer = 1'b0;
    end
    for (int i = 0; i < 3; i++) request(16'(120 + i), "wrap_tail");

    // full plus push during FETCH
    do_reset();
    for (int i = 0; i < 8; i++) push(16'(16'h0200 + i));
    check("fp_full", full, 1);
    exp_q.push_back(16'h0200);
    read_req_buffer = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b1;
    write_data = 16'h0F0F;
    @(posedge clk); #1;
    write_en = 1'b0;
    check("fp_count", count, 8);
    check("fp_overflow", overflow, 0);
    @(posedge clk); #1;
    read_req_buffer = 1'b0;
    for (int i = 1; i < 8; i++) request(16'(16'h0200 + i), "fp_drain");
    request(16'h0F0F, "fp_last");
    check("fp_end_empty", empty, 1);

    // async reset in RESP
    push(16'h5555);
    read_req_buffer = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ar_valid_before", valid, 1);
    rst = 1'b0;
    #1;
    check("ar_valid_drop", valid, 0);
    #1;
    rst = 1'b1;
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ar_wait_no_valid", valid, 0);
    end
    read_req_buffer = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
